// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg: shared state encodings, widths and start aliases for the EX-stage divider
package ex_div_unit_pkg;
  localparam int DIV_DATA_W = 32;
  localparam int DIV_RESULT_W = 2 * DIV_DATA_W;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  typedef enum logic [1:0] {
    div_idle = 2'd0,
    div_zero = 2'd1,
    div_run  = 2'd2,
    div_done = 2'd3
  } div_state_e;
endpackage

// File: rtl/ex_div_unit_step.sv
// ex_div_unit_step: one restoring-division step (in: rem, dvs, msb; out: rem_nxt, q_bit)
module ex_div_unit_step
  import ex_div_unit_pkg::*;
#(
  parameter int W = DIV_DATA_W
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] dvs,
  input  logic         msb,
  output logic [W-1:0] rem_nxt,
  output logic         q_bit
);
  logic [W:0] shifted;
  logic [W:0] diff;
  assign shifted = {rem, msb};
  assign diff = shifted - {1'b0, dvs};
  assign q_bit = ~diff[W];
  assign rem_nxt = q_bit ? diff[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 DIV/DIVU (in: clk, reset, start, signed_div, opdata1, opdata2, annul; out: result {rem,quo}, ready, stall_req)
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stall_req
);
  div_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] rem, dvd, dvs, rem_nxt, q_nxt;
  logic neg_q, neg_r, q_bit;
  logic neg1, neg2;
  ex_div_unit_step #(.W(DATA_W)) u_step (
    .rem(rem),
    .dvs(dvs),
    .msb(dvd[DATA_W-1]),
    .rem_nxt(rem_nxt),
    .q_bit(q_bit)
  );
  assign q_nxt = {dvd[DATA_W-2:0], q_bit};
  assign neg1 = signed_div & opdata1[DATA_W-1];
  assign neg2 = signed_div & opdata2[DATA_W-1];
  assign stall_req = start & ~ready;
  always_ff @(posedge clk) begin
    if (reset || annul) begin
      state  <= div_idle;
      cnt    <= '0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        div_idle: if (start) begin
          if (opdata2 == '0) begin
            state <= div_zero;
          end else begin
            state <= div_run;
            dvd   <= neg1 ? -opdata1 : opdata1;
            dvs   <= neg2 ? -opdata2 : opdata2;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
            cnt   <= '0;
            rem   <= '0;
          end
        end
        div_zero: begin
          state  <= start ? div_done : div_idle;
          ready  <= start;
          result <= '0;
        end
        div_run: if (!start) begin
          state <= div_idle;
        end else begin
          rem <= rem_nxt;
          dvd <= q_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state  <= div_done;
            ready  <= 1'b1;
            result <= {neg_r ? -rem_nxt : rem_nxt, neg_q ? -q_nxt : q_nxt};
          end
        end
        div_done: if (!start) begin
          state <= div_idle;
          ready <= 1'b0;
        end
        default: state <= div_idle;
      endcase
    end
  end
endmodule
